// File: rtl/dreimann_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dreimann_turn_ctrl
//  Purpose  : Three-player dice turn controller with debounced roll button,
//             roll timeout, result hold and extra roll on a six.
//  Revision : 1.0 - initial release
// ============================================================================
module dreimann_turn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       roll_done,
    input  logic [2:0] dice_val,
    output logic       roll_start,
    output logic [1:0] player,
    output logic [2:0] dice_q,
    output logic       show,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_SHOW = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    localparam int c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_TO_W    = (c_TO_BITS > 8) ? c_TO_BITS : 8;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_ONE    = c_TO_W'(1);

    logic                r_sync1, r_sync2;
    logic                r_db_level;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                r_armed;
    logic [c_DB_W-1:0]   r_arm_cnt;
    logic                w_db_flip;
    logic                w_press;

    state_t              r_state, w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [c_TO_W-1:0]   r_to_cnt, w_to_nxt;
    logic [2:0]          r_dice_q, w_dice_nxt;
    logic [1:0]          r_player, w_player_nxt;
    logic                r_roll_start, w_roll_start_nxt;
    logic                r_err, w_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_db_flip = (r_sync2 != r_db_level) && (r_db_cnt == c_DB_LAST);
    assign w_press   = w_db_flip && r_sync2 && r_armed;

    // Presses are only armed once the button has been seen low, debounced,
    // so a button already held through reset cannot start a roll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_armed    <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            if (r_sync2 != r_db_level) begin
                if (w_db_flip) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
            if (!r_armed) begin
                if (!r_db_level && !r_sync2) begin
                    if (r_arm_cnt == c_DB_LAST) r_armed <= 1'b1;
                    else                        r_arm_cnt <= r_arm_cnt + c_DB_ONE;
                end else begin
                    r_arm_cnt <= '0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold_cnt;
        w_to_nxt         = r_to_cnt;
        w_dice_nxt       = r_dice_q;
        w_player_nxt     = r_player;
        w_roll_start_nxt = 1'b0;
        w_err_nxt        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt      = ST_ROLL;
                    w_roll_start_nxt = 1'b1;
                    w_to_nxt         = '0;
                end
            end
            ST_ROLL: begin
                if (roll_done) begin
                    if ((dice_val != 3'd0) && (dice_val != 3'd7)) begin
                        w_dice_nxt  = dice_val;
                        w_hold_nxt  = c_HOLD_LAST;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt != '1) begin
                    w_to_nxt = r_to_cnt + c_TO_ONE;
                end
            end
            ST_SHOW: begin
                if (r_hold_cnt == '0) w_state_nxt = ST_NEXT;
                else                  w_hold_nxt  = r_hold_cnt - c_HOLD_ONE;
            end
            ST_NEXT: begin
                w_state_nxt = ST_IDLE;
                // A six grants the same player another roll.
                if (r_dice_q != 3'd6)
                    w_player_nxt = (r_player >= 2'd2) ? 2'd0 : r_player + 2'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_to_cnt     <= '0;
            r_dice_q     <= 3'd0;
            r_player     <= 2'd0;
            r_roll_start <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_to_cnt     <= w_to_nxt;
            r_dice_q     <= w_dice_nxt;
            r_player     <= w_player_nxt;
            r_roll_start <= w_roll_start_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign roll_start = r_roll_start;
    assign player     = r_player;
    assign dice_q     = r_dice_q;
    assign show       = (r_state == ST_SHOW);
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/dreimann_turn_ctrl.md
DREIMANN_TURN_CTRL -- requirements
Module: dreimann_turn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a button level change.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles a roll result is displayed before the turn advances.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for roll_done.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn  input  1  raw, asynchronous roll button; active-high.
REQ-007 roll_done  input  1  one-cycle pulse from the dice roller; dice_val is valid in the same cycle.
REQ-008 dice_val  input  3  roll result; legal values 1..6.
REQ-009 roll_start  output  1  one-cycle request pulse to the dice roller.
REQ-010 player  output  2  current player index, 0..2.
REQ-011 dice_q  output  3  latched last legal roll result.
REQ-012 show  output  1  high while a result is being displayed.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  one-cycle pulse on timeout or illegal dice_val.

Function
REQ-015 btn shall pass through a 2-flop synchronizer before any other use.
REQ-016 The debounced level shall change only after the synchronized btn has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch shall restart that count.
REQ-017 A press event shall be a 0->1 transition of the debounced level; one event per physical press.
REQ-018 FSM states: IDLE, ROLL, SHOW, NEXT.
REQ-019 IDLE: on a press event, roll_start = 1 for exactly one cycle (the cycle after the event), then go to ROLL.
REQ-020 ROLL: when roll_done = 1 and dice_val is in 1..6, latch dice_q <= dice_val, load the hold counter, and go to SHOW.
REQ-021 ROLL: when roll_done = 1 and dice_val is 0 or 7, pulse err, leave dice_q unchanged, keep player, and go to IDLE.
REQ-022 ROLL: if roll_done is absent for TIMEOUT_CYCLES cycles after roll_start, pulse err, keep player, and go to IDLE.
REQ-023 SHOW: show = 1 for exactly HOLD_CYCLES cycles, then go to NEXT.
REQ-024 NEXT (one cycle): if dice_q == 6, player is unchanged (extra roll); otherwise player advances 0->1->2->0. Then go to IDLE.
REQ-025 Press events in ROLL, SHOW or NEXT shall be discarded and never queued.
REQ-026 roll_done in IDLE, SHOW or NEXT shall be ignored.
REQ-027 A press event in the same cycle as the NEXT->IDLE transition shall be discarded; only events detected while in IDLE start a roll.
REQ-028 player shall never take the value 3.
REQ-029 The timeout counter shall be at least 8 bits wide and saturate; it shall never wrap.

Reset
REQ-030 While rst = 1: state = IDLE, player = 0, dice_q = 0, roll_start = 0, show = 0, busy = 0, err = 0, debounced level = 0, synchronizer = 0, all counters = 0.
REQ-031 Reset asserted in any state shall abort the operation immediately, with no roll_start, err or player update afterwards.
REQ-032 After rst deasserts, btn already held high shall not produce a press event until it has been seen low, debounced.

Verification
REQ-033 btn high for 5 cycles at reset defaults -> exactly one roll_start pulse; busy = 1; player = 0.
REQ-034 btn high for 2 cycles, then low -> no roll_start.
REQ-035 Roll with dice_val = 3 -> dice_q = 3, show high for 16 cycles, then player 0->1; three such rolls -> player returns to 0.
REQ-036 Roll with dice_val = 6 -> show high for 16 cycles, player unchanged; a second press is accepted afterwards.
REQ-037 roll_start with no roll_done -> err pulse after 255 cycles, state IDLE, player unchanged; dice_val = 7 with roll_done -> err pulse, dice_q unchanged.
REQ-038 rst pulsed mid-SHOW with player = 2 -> show = 0, player = 0, busy = 0 immediately; a button press during SHOW -> no second roll_start.
